// File: rtl/uart_tx_drain.sv
// Drains a show-ahead byte FIFO onto an 8N1 UART line, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_drain #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_deq,
   output logic                  tx,
   output logic                  busy
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   state_t                state, state_d;
   logic [BW-1:0]         baud_q, baud_d;
   logic [CW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  tx_d, busy_d;
   logic                  bit_end, load;
`ifdef UART_TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   assign bit_end = (baud_q == BAUD_LAST);
   // rstn gates load so no pop can be issued while reset is asserted
   assign load = ((state == IDLE) | ((state == STOP) & bit_end))
               & enable & ~fifo_empty & rstn;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx      <= tx_d;
         busy    <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:   if (load) state_d = START;
         START:  if (bit_end) state_d = DATA;
         DATA: begin
            if (bit_end && (bit_q == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
         PARITY: if (bit_end) state_d = STOP;
         STOP: begin
            if (load)
               state_d = START;
            else if (bit_end)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // tx/busy are computed from the next state so the registered
   // outputs line up with the state they describe
   always_comb begin
      fifo_deq = load;
      baud_d   = '0;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif
      if (state != IDLE && !load && !bit_end)
         baud_d = baud_q + 1'b1;
      if (load) begin
         shreg_d = fifo_data;
         bit_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = ^fifo_data;
`endif
      end else if (state == DATA && bit_end) begin
         bit_d   = bit_q + 1'b1;
         shreg_d = shreg_q >> 1;
      end
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with CLKS_PER_BIT=4.
// Frame tables switch with UART_TX_PARITY_EN.
module tb_uart_tx_drain;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rstn, enable;
   logic       fifo_empty, fifo_deq, tx, busy;
   logic [7:0] fifo_data;

   logic [7:0] mem [0:15];
   int         rd = 0, wr = 0, cyc = 0, ndeq = 0;
   int         deq_cyc [0:15];
   int         checks = 0, errors = 0;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] bits;
   } vec_t;
   vec_t vecs [4];

   uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rstn(rstn), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_deq(fifo_deq), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rd == wr);
   assign fifo_data  = mem[rd[3:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_deq) begin
         rd <= rd + 1;
         deq_cyc[ndeq[3:0]] <= cyc;
         ndeq <= ndeq + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr[3:0]] = d;
      wr = wr + 1;
   endtask

   task automatic idle_cycles(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk({name, " tx"}, 32'(tx), 32'd1);
         chk({name, " busy"}, 32'(busy), 32'd0);
         chk({name, " deq"}, 32'(fifo_deq), 32'd0);
      end
   endtask

   // Called with deq already high; checks the whole frame cycle by cycle.
   task automatic check_frame(input logic [10:0] bits, input logic more,
                              input int drop_at, input string name);
      chk({name, " deq"}, 32'(fifo_deq), 32'd1);
      for (int k = 0; k < NB * CPB; k++) begin
         @(posedge clk); #1;
         chk({name, " tx"}, 32'(tx), 32'(bits[k / CPB]));
         chk({name, " busy"}, 32'(busy), 32'd1);
         chk({name, " deq"}, 32'(fifo_deq),
             (k == NB * CPB - 1) ? 32'(more) : 32'd0);
         if (k == drop_at) enable = 1'b0;
      end
      if (!more) begin
         @(posedge clk); #1;
         chk({name, " end busy"}, 32'(busy), 32'd0);
         chk({name, " end tx"}, 32'(tx), 32'd1);
      end
   endtask

   logic [10:0] b_a5, b_00, b_ff, b_3c, b_01, b_5a;
   int          n0;

   initial begin
`ifdef UART_TX_PARITY_EN
      b_a5 = 11'h54A; b_00 = 11'h400; b_ff = 11'h5FE;
      b_3c = 11'h478; b_01 = 11'h602; b_5a = 11'h4B4;
      vecs[0] = '{8'h01, 11'h602};
      vecs[1] = '{8'h3C, 11'h478};
      vecs[2] = '{8'h5A, 11'h4B4};
      vecs[3] = '{8'h80, 11'h700};
`else
      b_a5 = 11'h34A; b_00 = 11'h200; b_ff = 11'h3FE;
      b_3c = 11'h278; b_01 = 11'h202; b_5a = 11'h2B4;
      vecs[0] = '{8'h01, 11'h202};
      vecs[1] = '{8'h3C, 11'h278};
      vecs[2] = '{8'h5A, 11'h2B4};
      vecs[3] = '{8'h80, 11'h300};
`endif
      rstn   = 1'b0;
      enable = 1'b1;
      push(8'hA5);
      idle_cycles(6, "rst_hold");

      rstn = 1'b1;
      #1;
      check_frame(b_a5, 1'b0, -1, "a5");
      chk("a5 ndeq", 32'(ndeq), 32'd1);

      for (int i = 0; i < 4; i++) begin
         push(vecs[i].data);
         #1;
         check_frame(vecs[i].bits, 1'b0, -1, $sformatf("vec%0d", i));
      end

      push(8'h00);
      push(8'hFF);
      #1;
      n0 = ndeq;
      check_frame(b_00, 1'b1, -1, "b2b_00");
      check_frame(b_ff, 1'b0, -1, "b2b_ff");
      chk("b2b gap", 32'(deq_cyc[(n0 + 1) % 16] - deq_cyc[n0 % 16]),
          32'(NB * CPB));

      enable = 1'b0;
      push(8'h3C);
      idle_cycles(12, "en_off");
      push(8'h01);
      enable = 1'b1;
      #1;
      n0 = ndeq;
      check_frame(b_3c, 1'b0, 3 * CPB, "en_drop");
      idle_cycles(8, "en_drop_idle");
      chk("en_drop ndeq", 32'(ndeq - n0), 32'd1);
      enable = 1'b1;
      #1;
      check_frame(b_01, 1'b0, -1, "en_resume");

      push(8'hA5);
      push(8'h5A);
      #1;
      n0 = ndeq;
      chk("mid_rst deq", 32'(fifo_deq), 32'd1);
      for (int k = 0; k < 17; k++) begin
         @(posedge clk); #1;
      end
      chk("mid_rst bit3", 32'(tx), 32'd0);
      rstn = 1'b0;
      #1;
      chk("mid_rst tx", 32'(tx), 32'd1);
      chk("mid_rst busy", 32'(busy), 32'd0);
      chk("mid_rst deq0", 32'(fifo_deq), 32'd0);
      idle_cycles(3, "mid_rst_hold");
      rstn = 1'b1;
      #1;
      check_frame(b_5a, 1'b0, -1, "after_rst");
      chk("after_rst ndeq", 32'(ndeq - n0), 32'd2);
      chk("after_rst empty", 32'(fifo_empty), 32'd1);
      idle_cycles(4, "final_idle");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
